ant_swarm_step: RTL and testbench
=================================

ANT_SWARM_STEP -- requirements
Module: ant_swarm_step

Interface
REQ-001 SHALL have parameter NUM_ANTS, default 4, ants processed per run (1..64).
REQ-002 SHALL have parameter X_W, default 8, x-coordinate width; parameter Y_W, default 7, y-coordinate width (X_W+Y_W <= 24, each <= 12).
REQ-003 SHALL have parameter ADDR_W, default 16, memory address width (<= 16); parameter RESULT_W, default 16, datapath result width (>= max(X_W,Y_W)).
REQ-004 SHALL have parameter X_MAX, default 156, and Y_MAX, default 116, inclusive upper coordinate bounds; parameter STEP, default 1, per-axis move magnitude (1..X_MAX and 1..Y_MAX).
REQ-005 SHALL have parameter COLOUR, default 3'b010, ant draw colour.
REQ-006 SHALL provide ports: clock in 1 system clock; resetn in 1 asynchronous active-low reset; start in 1 run request; finished out 1 idle flag; ant_index out 6 ant being processed; x_base in ADDR_W x-table base; y_base in ADDR_W y-table base; finished_dp in 1 datapath done; result_dp in RESULT_W datapath read data; start_dp out 1 datapath request; instruction_dp out 32 datapath instruction.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-008 SHALL encode instructions: LOAD {4'd2, zero pad, addr}; STORE {4'd3, zero pad, value zero-extended to 12 bits, addr zero-extended to 16 bits}; DRAW {4'd1, zero pad, 1'b1, colour[2:0], y, x}.
REQ-009 SHALL perform every datapath op as ISSUE (start_dp=1, instruction driven), HOLD (start_dp=1), WAIT (start_dp=0, leave on first cycle finished_dp=1); instruction_dp stable from ISSUE until WAIT exits.
REQ-010 SHALL, per ant i, sequence: LOAD x at x_base+i, LOAD y at y_base+i, COMPUTE (1 cycle), [ERASE], STORE x, STORE y, DRAW, then NEXT; address sums wrap modulo 2^ADDR_W.
REQ-011 SHALL capture result_dp[X_W-1:0] (resp. [Y_W-1:0]) on the WAIT exit cycle of each LOAD.
REQ-012 SHALL keep one direction bit per ant per axis (0 = increasing), internal.
REQ-013 SHALL in COMPUTE, direction increasing: if coord+STEP > MAX then coord=MAX and flip bit, else coord+=STEP; decreasing: if coord < STEP then coord=0 and flip bit, else coord-=STEP; arithmetic one bit wider than coord, no wrap.
REQ-014 SHALL clamp a loaded coordinate above MAX to MAX before stepping.
REQ-015 SHALL in IDLE hold finished=1 and start_dp=0; start=1 in IDLE sets finished=0 next cycle and begins ant 0.
REQ-016 SHALL ignore start while not IDLE.
REQ-017 SHALL in NEXT increment ant_index, or on ant NUM_ANTS-1 return to IDLE with ant_index=0; finished rises the cycle after the last DRAW WAIT exit.
REQ-018 SHALL drive ant_index equal to the ant currently processed, 0 in IDLE.

Reset
REQ-019 SHALL on resetn=0, immediately and regardless of state: state IDLE, finished=1, start_dp=0, instruction_dp=0, ant_index=0, coordinate registers 0, all direction bits 0.
REQ-020 SHALL abandon any pending datapath op on reset; a finished_dp arriving later in IDLE is ignored.

Configuration
REQ-021 SHALL, with macro ANT_SWARM_ERASE_EN defined, insert ERASE after COMPUTE: DRAW op with colour 3'b000 at the pre-step loaded coordinates.
REQ-022 SHALL, without ANT_SWARM_ERASE_EN, omit ERASE; COMPUTE proceeds directly to STORE x.

Verification
REQ-023 Reset mid-WAIT of ant 2 LOAD y -> next cycle finished=1, start_dp=0, ant_index=0; subsequent start runs all ants from ant 0.
REQ-024 NUM_ANTS=1, x=10, y=20, directions 0, finished_dp after 1 cycle -> stores 11, 21; DRAW = {4'd1, 9'd0, 1'b1, 3'b010, 7'd21, 8'd11}.
REQ-025 x=156, dir increasing -> x stores 156, bit flips; next run with x=156 stores 155.
REQ-026 y=0, dir decreasing -> y stores 0, bit flips; next run stores 1; loaded x=200 -> clamped then stored 156.
REQ-027 start pulsed while ant 1 in progress -> ignored; run ends after NUM_ANTS ants; exactly 5 start_dp bursts per ant (6 with ANT_SWARM_ERASE_EN, ERASE colour 3'b000 at old coords).
REQ-028 x_base=16'hFFFF, NUM_ANTS=2 -> ant 1 LOAD x address 16'h0000; finished_dp delayed 10 cycles -> instruction_dp stable throughout WAIT.

Source files
------------

// File: rtl/ant_swarm_step.sv
// Ant swarm stepper: per ant, load x/y, bounce-step, store back and draw through a handshaked datapath.
// Each op takes at least 3 cycles and stalls in WAIT until finished_dp; ANT_SWARM_ERASE_EN adds an erase DRAW.
module ant_swarm_step #(
    parameter int          NUM_ANTS = 4,
    parameter int          X_W      = 8,
    parameter int          Y_W      = 7,
    parameter int          ADDR_W   = 16,
    parameter int          RESULT_W = 16,
    parameter int          X_MAX    = 156,
    parameter int          Y_MAX    = 116,
    parameter int          STEP     = 1,
    parameter logic [2:0]  COLOUR   = 3'b010
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    output logic                finished,
    output logic [5:0]          ant_index,
    input  logic [ADDR_W-1:0]   x_base,
    input  logic [ADDR_W-1:0]   y_base,
    input  logic                finished_dp,
    input  logic [RESULT_W-1:0] result_dp,
    output logic                start_dp,
    output logic [31:0]         instruction_dp
);
    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_LDX   = 4'd1;
    localparam logic [3:0] S_LDY   = 4'd2;
    localparam logic [3:0] S_COMP  = 4'd3;
    localparam logic [3:0] S_ERASE = 4'd4;
    localparam logic [3:0] S_STX   = 4'd5;
    localparam logic [3:0] S_STY   = 4'd6;
    localparam logic [3:0] S_DRAW  = 4'd7;

    localparam logic [1:0] P_ISSUE = 2'd0;
    localparam logic [1:0] P_HOLD  = 2'd1;
    localparam logic [1:0] P_WAIT  = 2'd2;

    localparam logic [X_W:0] XMAX_W = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] YMAX_W = (Y_W+1)'(Y_MAX);
    localparam logic [X_W:0] STEP_X = (X_W+1)'(STEP);
    localparam logic [Y_W:0] STEP_Y = (Y_W+1)'(STEP);

    logic [3:0]     state_q, state_d;
    logic [1:0]     ph_q, ph_d;
    logic [5:0]     ant_q, ant_d;
    logic [X_W-1:0] lx_q, lx_d, nx_q, nx_d;
    logic [Y_W-1:0] ly_q, ly_d, ny_q, ny_d;
    logic [63:0]    dirx_q, dirx_d, diry_q, diry_d;

    logic           is_op;
    logic [X_W:0]   cx, sx;
    logic [Y_W:0]   cy, sy;
    logic           flip_x, flip_y;
    logic [ADDR_W-1:0] x_addr, y_addr;
    logic           unused_bits;

    assign is_op  = (state_q != S_IDLE) && (state_q != S_COMP);
    assign x_addr = x_base + ADDR_W'(ant_q);
    assign y_addr = y_base + ADDR_W'(ant_q);
    assign unused_bits = &{1'b0, result_dp, sx[X_W], sy[Y_W]};

    // Bounce step: out-of-range loads are clamped first, then stepping saturates at the walls and reverses.
    always_comb begin
        cx = ({1'b0, lx_q} > XMAX_W) ? XMAX_W : {1'b0, lx_q};
        cy = ({1'b0, ly_q} > YMAX_W) ? YMAX_W : {1'b0, ly_q};
        sx = '0;
        sy = '0;
        flip_x = 1'b0;
        flip_y = 1'b0;
        if (!dirx_q[ant_q]) begin
            sx = cx + STEP_X;
            if (sx > XMAX_W) begin
                sx = XMAX_W;
                flip_x = 1'b1;
            end
        end else if (cx < STEP_X) begin
            flip_x = 1'b1;
        end else begin
            sx = cx - STEP_X;
        end
        if (!diry_q[ant_q]) begin
            sy = cy + STEP_Y;
            if (sy > YMAX_W) begin
                sy = YMAX_W;
                flip_y = 1'b1;
            end
        end else if (cy < STEP_Y) begin
            flip_y = 1'b1;
        end else begin
            sy = cy - STEP_Y;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        ant_d   = ant_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        dirx_d  = dirx_q;
        diry_d  = diry_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_LDX;
                ph_d    = P_ISSUE;
                ant_d   = 6'd0;
            end
        end else if (state_q == S_COMP) begin
            nx_d   = sx[X_W-1:0];
            ny_d   = sy[Y_W-1:0];
            dirx_d = dirx_q ^ (64'(flip_x) << ant_q);
            diry_d = diry_q ^ (64'(flip_y) << ant_q);
`ifdef ANT_SWARM_ERASE_EN
            state_d = S_ERASE;
`else
            state_d = S_STX;
`endif
        end else if (ph_q == P_ISSUE) begin
            ph_d = P_HOLD;
        end else if (ph_q == P_HOLD) begin
            ph_d = P_WAIT;
        end else if (finished_dp) begin
            ph_d = P_ISSUE;
            case (state_q)
                S_LDX: begin
                    lx_d    = result_dp[X_W-1:0];
                    state_d = S_LDY;
                end
                S_LDY: begin
                    ly_d    = result_dp[Y_W-1:0];
                    state_d = S_COMP;
                end
                S_ERASE: state_d = S_STX;
                S_STX:   state_d = S_STY;
                S_STY:   state_d = S_DRAW;
                default: begin
                    // Last DRAW exit goes straight to IDLE so finished rises on the following cycle.
                    if (ant_q == 6'(NUM_ANTS - 1)) begin
                        state_d = S_IDLE;
                        ant_d   = 6'd0;
                    end else begin
                        state_d = S_LDX;
                        ant_d   = ant_q + 6'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ph_q    <= P_ISSUE;
            ant_q   <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            dirx_q  <= '0;
            diry_q  <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            ant_q   <= ant_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
        end
    end

    assign finished  = (state_q == S_IDLE);
    assign ant_index = ant_q;
    assign start_dp  = is_op && (ph_q != P_WAIT);

    always_comb begin
        instruction_dp = '0;
        case (state_q)
            S_LDX: begin
                instruction_dp[31:28]       = 4'd2;
                instruction_dp[ADDR_W-1:0]  = x_addr;
            end
            S_LDY: begin
                instruction_dp[31:28]       = 4'd2;
                instruction_dp[ADDR_W-1:0]  = y_addr;
            end
            S_ERASE: begin
                instruction_dp[31:28]           = 4'd1;
                instruction_dp[X_W+Y_W+3]       = 1'b1;
                instruction_dp[X_W+Y_W+2 -: 3]  = 3'b000;
                instruction_dp[X_W+Y_W-1:X_W]   = ly_q;
                instruction_dp[X_W-1:0]         = lx_q;
            end
            S_STX: begin
                instruction_dp[31:28]       = 4'd3;
                instruction_dp[16 +: X_W]   = nx_q;
                instruction_dp[ADDR_W-1:0]  = x_addr;
            end
            S_STY: begin
                instruction_dp[31:28]       = 4'd3;
                instruction_dp[16 +: Y_W]   = ny_q;
                instruction_dp[ADDR_W-1:0]  = y_addr;
            end
            S_DRAW: begin
                instruction_dp[31:28]           = 4'd1;
                instruction_dp[X_W+Y_W+3]       = 1'b1;
                instruction_dp[X_W+Y_W+2 -: 3]  = COLOUR;
                instruction_dp[X_W+Y_W-1:X_W]   = ny_q;
                instruction_dp[X_W-1:0]         = nx_q;
            end
            default: instruction_dp = '0;
        endcase
    end
endmodule

// File: tb/tb_ant_swarm_step.sv
// Directed bench for ant_swarm_step with a behavioural memory/datapath responder.
module tb_ant_swarm_step;
    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic        finished;
    logic [5:0]  ant_index;
    logic [15:0] x_base, y_base;
    logic        finished_dp;
    logic        fdp_resp, fdp_tb;
    logic [15:0] result_dp;
    logic        start_dp;
    logic [31:0] instruction_dp;

    int n_checks = 0;
    int n_errs   = 0;
    int bursts   = 0;
    int stab_err = 0;
    int dp_dly   = 1;
    logic [31:0] instr_log [$];
    logic [15:0] mem [0:65535];

    assign finished_dp = fdp_resp | fdp_tb;

    ant_swarm_step dut (
        .clock(clock), .resetn(resetn), .start(start), .finished(finished),
        .ant_index(ant_index), .x_base(x_base), .y_base(y_base),
        .finished_dp(finished_dp), .result_dp(result_dp),
        .start_dp(start_dp), .instruction_dp(instruction_dp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Datapath model: LOAD reads mem, STORE writes mem; finished_dp comes dp_dly cycles into WAIT.
    initial begin : responder
        logic [31:0] cur;
        logic synced, aborted;
        int k;
        fdp_resp = 1'b0;
        result_dp = 16'h0;
        synced = 1'b0;
        forever begin
            if (!synced) begin
                @(posedge clock); #1;
            end
            synced = 1'b0;
            if (resetn && start_dp) begin
                cur = instruction_dp;
                instr_log.push_back(cur);
                bursts++;
                @(posedge clock); #1;
                if (instruction_dp !== cur || !start_dp) stab_err++;
                @(posedge clock); #1;
                aborted = !resetn;
                k = 1;
                while (k < dp_dly && !aborted) begin
                    if (instruction_dp !== cur || start_dp) stab_err++;
                    @(posedge clock); #1;
                    if (!resetn) aborted = 1'b1;
                    k++;
                end
                if (!aborted) begin
                    if (instruction_dp !== cur) stab_err++;
                    if (cur[31:28] == 4'd2) result_dp = mem[cur[15:0]];
                    if (cur[31:28] == 4'd3) mem[cur[15:0]] = {4'h0, cur[27:16]};
                    fdp_resp = 1'b1;
                    @(posedge clock); #1;
                    fdp_resp = 1'b0;
                end
                synced = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clock); #2;
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic run_swarm(input string tag, input int budget);
        int n;
        pulse_start();
        chk({tag, "_busy"}, {31'd0, finished}, 32'd0);
        n = 0;
        while (!finished && n < budget) begin
            @(posedge clock); #2;
            n++;
        end
        chk({tag, "_done"}, {31'd0, finished}, 32'd1);
        chk({tag, "_idx0"}, {26'd0, ant_index}, 32'd0);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        start  = 1'b0;
        fdp_tb = 1'b0;
        x_base = 16'h0100;
        y_base = 16'h0200;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_finished", {31'd0, finished}, 32'd1);
        chk("rst_start_dp", {31'd0, start_dp}, 32'd0);
        chk("rst_instr", instruction_dp, 32'd0);
        chk("rst_ant", {26'd0, ant_index}, 32'd0);
        resetn = 1'b1;

        // Run 1: basic step, right wall, clamp, plus a start pulse during ant 1.
        mem[16'h0100] = 16'd10;  mem[16'h0200] = 16'd20;
        mem[16'h0101] = 16'd156; mem[16'h0201] = 16'd116;
        mem[16'h0102] = 16'd200; mem[16'h0202] = 16'd5;
        mem[16'h0103] = 16'd0;   mem[16'h0203] = 16'd0;
        dp_dly = 1; bursts = 0; instr_log.delete();
        fork
            run_swarm("run1", 3000);
            begin
                n = 0;
                while (ant_index != 6'd1 && n < 500) begin
                    @(posedge clock); #2;
                    n++;
                end
                start = 1'b1;
                @(posedge clock); #2;
                start = 1'b0;
            end
        join
        repeat (5) @(posedge clock);
        #2;
        chk("run1_restart_ignored", {31'd0, finished}, 32'd1);
        chk("run1_bursts", bursts, 20);
        chk("run1_store_x_instr", instr_log[2], 32'h300B_0100);
        chk("run1_draw0", instr_log[4], 32'h1005_150B);
        chk("run1_x0", {16'd0, mem[16'h0100]}, 32'd11);
        chk("run1_y0", {16'd0, mem[16'h0200]}, 32'd21);
        chk("run1_x1_wall", {16'd0, mem[16'h0101]}, 32'd156);
        chk("run1_y1_wall", {16'd0, mem[16'h0201]}, 32'd116);
        chk("run1_x2_clamp", {16'd0, mem[16'h0102]}, 32'd156);
        chk("run1_y2", {16'd0, mem[16'h0202]}, 32'd6);
        chk("run1_x3", {16'd0, mem[16'h0103]}, 32'd1);

        // Run 2: reversed directions after the wall hits, and the floor at y=0.
        mem[16'h0201] = 16'd0;
        bursts = 0; instr_log.delete();
        run_swarm("run2", 3000);
        chk("run2_x0", {16'd0, mem[16'h0100]}, 32'd12);
        chk("run2_x1_back", {16'd0, mem[16'h0101]}, 32'd155);
        chk("run2_y1_floor", {16'd0, mem[16'h0201]}, 32'd0);
        chk("run2_x2_back", {16'd0, mem[16'h0102]}, 32'd155);
        chk("run2_y2", {16'd0, mem[16'h0202]}, 32'd7);

        // Run 3: x table wraps past 16'hFFFF, slow datapath.
        x_base = 16'hFFFF;
        mem[16'hFFFF] = 16'd50; mem[16'h0000] = 16'd100;
        mem[16'h0001] = 16'd0;  mem[16'h0002] = 16'd156;
        dp_dly = 10; bursts = 0; stab_err = 0; instr_log.delete();
        run_swarm("run3", 6000);
        chk("run3_ldx_ant0", instr_log[0], 32'h2000_FFFF);
        chk("run3_ldx_ant1_wrap", instr_log[5], 32'h2000_0000);
        chk("run3_draw1", instr_log[9], 32'h1005_0163);
        chk("run3_instr_stable", stab_err, 0);
        chk("run3_x0", {16'd0, mem[16'hFFFF]}, 32'd51);
        chk("run3_x1", {16'd0, mem[16'h0000]}, 32'd99);
        chk("run3_x2_floor", {16'd0, mem[16'h0001]}, 32'd0);
        chk("run3_x3_wall", {16'd0, mem[16'h0002]}, 32'd156);
        chk("run3_y1_up", {16'd0, mem[16'h0201]}, 32'd1);

        // Run 4: reset while ant 2 waits on its y load.
        x_base = 16'h0100;
        dp_dly = 20; bursts = 0; instr_log.delete();
        pulse_start();
        n = 0;
        while (bursts < 12 && n < 2000) begin
            @(posedge clock); #2;
            n++;
        end
        chk("run4_reached_ldy2", bursts, 12);
        repeat (3) @(posedge clock);
        #3;
        chk("run4_pre_rst_ant", {26'd0, ant_index}, 32'd2);
        resetn = 1'b0;
        @(posedge clock); #2;
        chk("run4_rst_finished", {31'd0, finished}, 32'd1);
        chk("run4_rst_start_dp", {31'd0, start_dp}, 32'd0);
        chk("run4_rst_ant", {26'd0, ant_index}, 32'd0);
        chk("run4_rst_instr", instruction_dp, 32'd0);
        resetn = 1'b1;
        @(posedge clock); #2;
        fdp_tb = 1'b1;
        @(posedge clock); #2;
        fdp_tb = 1'b0;
        @(posedge clock); #2;
        chk("run4_late_fdp_finished", {31'd0, finished}, 32'd1);
        chk("run4_late_fdp_start_dp", {31'd0, start_dp}, 32'd0);

        // Run 5: after reset all directions are increasing again.
        mem[16'h0101] = 16'd99;
        dp_dly = 1; bursts = 0; instr_log.delete();
        run_swarm("run5", 3000);
        chk("run5_bursts", bursts, 20);
        chk("run5_first_instr", instr_log[0], 32'h2000_0100);
        chk("run5_x1_dir_reset", {16'd0, mem[16'h0101]}, 32'd100);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
